// File: rtl/mem_responder.sv
// mem_responder
//   Single-outstanding word-addressed memory responder with a fixed,
//   parameterised response latency and a valid/ready handshake on both
//   the request and the response side.
//
// Parameters
//   DEPTH    number of 32-bit words stored (power of two, >= 4)
//   LATENCY  cycles from request acceptance to response valid (>= 1)
//
// Ports
//   CLOCK_50    in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   initiator presents a request
//   req_ready   out  responder accepts a request this cycle (IDLE only)
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   resp_valid  out  response present (RESP only)
//   resp_ready  in   initiator accepts the response
//   resp_rdata  out  load data; 0 for stores and errors
//   resp_err    out  request was misaligned or out of range
module mem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;

   logic            we_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;

   logic [31:0]     mem [DEPTH];

   logic            cur_we;
   logic [31:0]     cur_addr;
   logic [31:0]     cur_wdata;
   logic            cur_err;
   logic [AW-1:0]   cur_idx;

   logic            accept;
   logic            enter_resp;

   // With LATENCY=1 the RESP edge is the acceptance edge, so the request
   // must be taken straight from the inputs; otherwise from the registers.
   always_comb begin
      if (state == IDLE) begin
         cur_we    = req_we;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
      end else begin
         cur_we    = we_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
      cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (AW + 2)) != 32'd0);
      cur_idx = cur_addr[AW+1:2];
   end

   // Next-state and handshake outputs
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      accept     = 1'b0;
      enter_resp = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_n    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_n = BUSY;
                  cnt_n   = CW'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            if (cnt == CW'(1)) begin
               state_n    = RESP;
               enter_resp = 1'b1;
               cnt_n      = '0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // State, request capture and response registers
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (enter_resp) begin
            resp_err   <= cur_err;
            resp_rdata <= (cur_we || cur_err) ? '0 : mem[cur_idx];
         end
      end
   end

   // Storage is never cleared. reset_n gates the write because with
   // LATENCY=1 enter_resp is driven from IDLE, which reset does not block.
   always_ff @(posedge CLOCK_50) begin
      if (reset_n && enter_resp && cur_we && !cur_err) begin
         mem[cur_idx] <= cur_wdata;
      end
   end

endmodule
